// File: rtl/wbr_pkg.sv
// Shared types and strobe encodings for the wrapper boundary register access controller.
package wbr_pkg;

    localparam int unsigned STB_W = 4;

    // Bit positions of the cell strobes inside the strobe vector
    localparam int unsigned STB_CAPTURE_BIT  = 0;
    localparam int unsigned STB_SHIFT_BIT    = 1;
    localparam int unsigned STB_TRANSFER_BIT = 2;
    localparam int unsigned STB_UPDATE_BIT   = 3;

    localparam logic [STB_W-1:0] STB_NONE     = 4'b0000;
    localparam logic [STB_W-1:0] STB_CAPTURE  = 4'b0001;
    localparam logic [STB_W-1:0] STB_SHIFT    = 4'b0010;
    localparam logic [STB_W-1:0] STB_TRANSFER = 4'b0100;
    localparam logic [STB_W-1:0] STB_UPDATE   = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CAPTURE  = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_TRANSFER = 3'd3,
        ST_UPDATE   = 3'd4,
        ST_DONE     = 3'd5
    } wbr_acc_state_e;

    typedef struct packed {
        logic capture;
        logic transfer;
        logic update;
        logic mode;
        logic safe;
        logic io_face;
    } wbr_acc_op_t;

    // One-hot strobe pattern driven to the cells while in a given state
    function automatic logic [STB_W-1:0] stb_of_state(input wbr_acc_state_e st);
        logic [STB_W-1:0] stb;
        stb = STB_NONE;
        case (st)
            ST_CAPTURE:  stb = STB_CAPTURE;
            ST_SHIFT:    stb = STB_SHIFT;
            ST_TRANSFER: stb = STB_TRANSFER;
            ST_UPDATE:   stb = STB_UPDATE;
            default:     stb = STB_NONE;
        endcase
        return stb;
    endfunction

endpackage

// File: rtl/wbr_shift_counter.sv
// Shift-cycle counter: counts enabled cycles up to CHAIN_LEN and saturates there.
module wbr_shift_counter #(
    parameter int unsigned CHAIN_LEN = 8,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic clk,
    input  logic arst,
    input  logic clr,
    input  logic en,
    output logic last_c
);

    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating at CHAIN_LEN keeps a 1-cell chain from wrapping
    always_comb begin : cnt_next
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_END)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin : cnt_reg
        if (arst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High in the cycle whose closing edge brings the count to CHAIN_LEN
    assign last_c = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/wbr_access_ctrl.sv
// Serial access controller for a wrapper boundary register chain: loads stimulus,
// returns captured contents and sequences capture/shift/transfer/update strobes.
module wbr_access_ctrl
    import wbr_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 8
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 start,
    input  logic                 do_capture,
    input  logic                 do_transfer,
    input  logic                 do_update,
    input  logic                 cfg_mode,
    input  logic                 cfg_safe,
    input  logic                 cfg_io_face,
    input  logic [CHAIN_LEN-1:0] wr_data,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] rd_data,
    output logic                 wsi,
    input  logic                 wso,
    output logic                 shift,
    output logic                 capture,
    output logic                 transfer,
    output logic                 update,
    output logic                 mode,
    output logic                 safe,
    output logic                 io_face
);

    localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int unsigned RX_MSB = CHAIN_LEN - 1;

    wbr_acc_state_e   state_q, state_d;
    wbr_acc_op_t      op_q, op_d;
    logic [CHAIN_LEN-1:0] tx_q, tx_d;
    logic [CHAIN_LEN-1:0] rx_q, rx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wsi_q, wsi_d;
    logic [STB_W-1:0] stb_q, stb_d;
    logic             cnt_clr_c;
    logic             cnt_en_c;
    logic             cnt_last_c;

    wbr_shift_counter #(
        .CHAIN_LEN (CHAIN_LEN),
        .CNT_W     (CNT_W)
    ) u_shift_counter (
        .clk    (clk),
        .arst   (arst),
        .clr    (cnt_clr_c),
        .en     (cnt_en_c),
        .last_c (cnt_last_c)
    );

    // State, operation latch, TX/RX shift registers and registered outputs
    always_ff @(posedge clk) begin : state_reg
        if (arst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wsi_q   <= 1'b0;
            stb_q   <= STB_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wsi_q   <= wsi_d;
            stb_q   <= stb_d;
        end
    end

    always_comb begin : next_state_comb
        state_d   = state_q;
        op_d      = op_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        cnt_clr_c = 1'b0;
        cnt_en_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d.capture  = do_capture;
                    op_d.transfer = do_transfer;
                    op_d.update   = do_update;
                    op_d.mode     = cfg_mode;
                    op_d.safe     = cfg_safe;
                    op_d.io_face  = cfg_io_face;
                    tx_d          = wr_data;
                    cnt_clr_c     = 1'b1;
                    state_d       = do_capture ? ST_CAPTURE : ST_SHIFT;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Stimulus leaves LSB first; the first returned bit lands in position 0
                cnt_en_c     = 1'b1;
                tx_d         = tx_q >> 1;
                rx_d         = rx_q >> 1;
                rx_d[RX_MSB] = wso;
                if (cnt_last_c) begin
                    if (op_q.transfer) begin
                        state_d = ST_TRANSFER;
                    end else if (op_q.update) begin
                        state_d = ST_UPDATE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_TRANSFER: begin
                state_d = op_q.update ? ST_UPDATE : ST_DONE;
            end
            ST_UPDATE: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so each flop lines up with its state
    always_comb begin : output_comb
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        stb_d  = stb_of_state(state_d);
        wsi_d  = (state_d == ST_SHIFT) ? tx_d[0] : 1'b0;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rx_q;
    assign wsi      = wsi_q;
    assign capture  = stb_q[STB_CAPTURE_BIT];
    assign shift    = stb_q[STB_SHIFT_BIT];
    assign transfer = stb_q[STB_TRANSFER_BIT];
    assign update   = stb_q[STB_UPDATE_BIT];
    assign mode     = op_q.mode;
    assign safe     = op_q.safe;
    assign io_face  = op_q.io_face;

endmodule

// File: tb/tb_wbr_access_ctrl.sv
// Scoreboard bench for wbr_access_ctrl driving behavioural 8-cell and 1-cell chains.
`timescale 1ns/1ps
module tb_wbr_access_ctrl;

    localparam int unsigned N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         arst, start, do_capture, do_transfer, do_update;
    logic         cfg_mode, cfg_safe, cfg_io_face;
    logic [N-1:0] wr_data, rd_data;
    logic         busy, done, wsi, wso, shift, capture, transfer, update, mode, safe, io_face;

    logic         start1;
    logic [0:0]   wr_data1, rd_data1;
    logic         busy1, done1, wsi1, wso1, shift1, capture1, transfer1, update1;
    logic         mode1, safe1, io_face1;

    wbr_access_ctrl #(.CHAIN_LEN(N)) u_dut (
        .clk(clk), .arst(arst), .start(start), .do_capture(do_capture),
        .do_transfer(do_transfer), .do_update(do_update), .cfg_mode(cfg_mode),
        .cfg_safe(cfg_safe), .cfg_io_face(cfg_io_face), .wr_data(wr_data),
        .busy(busy), .done(done), .rd_data(rd_data), .wsi(wsi), .wso(wso),
        .shift(shift), .capture(capture), .transfer(transfer), .update(update),
        .mode(mode), .safe(safe), .io_face(io_face)
    );

    wbr_access_ctrl #(.CHAIN_LEN(1)) u_dut1 (
        .clk(clk), .arst(arst), .start(start1), .do_capture(do_capture),
        .do_transfer(do_transfer), .do_update(do_update), .cfg_mode(cfg_mode),
        .cfg_safe(cfg_safe), .cfg_io_face(cfg_io_face), .wr_data(wr_data1),
        .busy(busy1), .done(done1), .rd_data(rd_data1), .wsi(wsi1), .wso(wso1),
        .shift(shift1), .capture(capture1), .transfer(transfer1), .update(update1),
        .mode(mode1), .safe(safe1), .io_face(io_face1)
    );

    // Behavioural chains: sr = shift stages (position 0 next to wso), ur = update stages
    logic [N-1:0] sr, ur, cap_src, ld_val;
    logic         ld;
    always @(posedge clk) begin
        if (ld)           sr <= ld_val;
        else if (capture) sr <= cap_src;
        else if (shift)   sr <= {wsi, sr[N-1:1]};
        if (update)       ur <= sr;
    end
    assign wso = sr[0];

    logic sr1, ur1, cap_src1, ld1, ld_val1;
    always @(posedge clk) begin
        if (ld1)           sr1 <= ld_val1;
        else if (capture1) sr1 <= cap_src1;
        else if (shift1)   sr1 <= wsi1;
        if (update1)       ur1 <= sr1;
    end
    assign wso1 = sr1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    typedef struct {
        logic [N-1:0] rd;
        logic [N-1:0] chain;
        int           len;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic mon_act = 1'b0;
    int   mon_cnt = 0;
    int   n_done  = 0;

    // Monitor: tracks the expected busy window and scores each done against the queue
    always @(negedge clk) begin
        if (arst) begin
            mon_act = 1'b0;
            mon_cnt = 0;
        end else begin
            if (mon_act) mon_cnt++;
            chk("busy", 32'(busy), 32'(mon_act));
            chk("strobe_onehot", 32'($countones({shift, capture, transfer, update}) <= 1), 32'd1);
            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'(done), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("access_len", 32'(mon_cnt), 32'(mon_e.len));
                    chk("rd_data", 32'(rd_data), 32'(mon_e.rd));
                    chk("chain_update", 32'(ur), 32'(mon_e.chain));
                end
                mon_act = 1'b0;
            end
            if (!mon_act && start) begin
                mon_act = 1'b1;
                mon_cnt = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic launch(input logic c, input logic t, input logic u, input logic [N-1:0] wr,
                          input logic [N-1:0] exp_rd, input logic [N-1:0] exp_chain);
        exp_t e;
        do_capture  = c;
        do_transfer = t;
        do_update   = u;
        wr_data     = wr;
        e.rd        = exp_rd;
        e.chain     = exp_chain;
        e.len       = int'(c) + int'(N) + int'(t) + int'(u) + 1;
        sb.push_back(e);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 64) begin
            cyc();
            k++;
        end
        chk("done_seen", 32'(done), 32'd1);
        cyc();
    endtask

    int nd;

    initial begin
        arst = 1'b1; start = 1'b0; start1 = 1'b0;
        do_capture = 1'b0; do_transfer = 1'b0; do_update = 1'b0;
        cfg_mode = 1'b0; cfg_safe = 1'b0; cfg_io_face = 1'b0;
        wr_data = '0; wr_data1 = '0;
        ld = 1'b0; ld_val = '0; cap_src = '0;
        ld1 = 1'b0; ld_val1 = 1'b0; cap_src1 = 1'b0;
        cyc(); cyc();
        chk("reset_outs", 32'({busy, done, wsi, shift, capture, transfer, update, mode, safe, io_face}), 32'd0);
        chk("reset_rd", 32'(rd_data), 32'd0);
        chk("reset_outs_l1", 32'({busy1, done1, wsi1, shift1, capture1, transfer1, update1,
                                  mode1, safe1, io_face1, rd_data1}), 32'd0);
        arst = 1'b0;
        ld = 1'b1; ld_val = 8'h3C; cap_src = 8'h3C;
        cyc();
        ld = 1'b0;

        // Full op: captured 3C comes back, A5 lands in the update stages, 12-cycle access
        launch(1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 8'hA5);
        wait_done();

        // Pure shift, back to back: each returns the previous chain contents
        launch(1'b0, 1'b0, 1'b0, 8'h01, 8'hA5, 8'hA5);
        wait_done();
        launch(1'b0, 1'b0, 1'b0, 8'h80, 8'h01, 8'hA5);
        wait_done();

        // start pulsed mid-shift with different data must be ignored
        nd = n_done;
        launch(1'b0, 1'b0, 1'b0, 8'hFF, 8'h80, 8'hA5);
        cyc(); cyc(); cyc();
        wr_data = 8'h00;
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done();
        repeat (12) cyc();
        chk("single_done", 32'(n_done - nd), 32'd1);
        chk("idle_after_ignore", 32'(busy), 32'd0);

        // Configuration latched at accept and held while the inputs toggle
        cfg_mode = 1'b1; cfg_safe = 1'b1; cfg_io_face = 1'b0; cap_src = 8'h69;
        launch(1'b1, 1'b1, 1'b1, 8'h0F, 8'h69, 8'h0F);
        for (int k = 0; k < 64; k++) begin
            chk("mode_hold", 32'(mode), 32'd1);
            chk("safe_hold", 32'(safe), 32'd1);
            chk("io_face_hold", 32'(io_face), 32'd0);
            if (done) break;
            cfg_mode = ~cfg_mode; cfg_safe = ~cfg_safe; cfg_io_face = ~cfg_io_face;
            cyc();
        end
        chk("done_seen_cfg", 32'(done), 32'd1);
        cyc();
        chk("mode_after_done", 32'({mode, safe, io_face}), 32'b110);

        // Reset during the 4th shift cycle abandons the access
        cfg_mode = 1'b1; cfg_safe = 1'b1; cfg_io_face = 1'b1;
        nd = n_done;
        launch(1'b0, 1'b0, 1'b0, 8'h55, 8'h00, 8'h00);
        cyc(); cyc(); cyc();
        arst = 1'b1;
        cyc();
        chk("midreset_outs", 32'({busy, done, wsi, shift, capture, transfer, update, mode, safe, io_face}), 32'd0);
        chk("midreset_rd", 32'(rd_data), 32'd0);
        sb.delete();
        cyc();
        arst = 1'b0;
        cyc(); cyc();
        chk("no_done_on_reset", 32'(n_done - nd), 32'd0);
        cap_src = 8'h96;
        launch(1'b1, 1'b0, 1'b1, 8'h5A, 8'h96, 8'h5A);
        wait_done();

        // Single-cell chain, capture + update: one shift cycle, done in cycle 4
        for (int tcase = 0; tcase < 2; tcase++) begin
            int sh, dc;
            sh = 0; dc = 0;
            ld1 = 1'b1; ld_val1 = (tcase == 0) ? 1'b0 : 1'b1;
            cap_src1 = (tcase == 0) ? 1'b0 : 1'b1;
            cyc();
            ld1 = 1'b0;
            do_capture = 1'b1; do_transfer = 1'b0; do_update = 1'b1;
            wr_data1 = (tcase == 0) ? 1'b1 : 1'b0;
            start1 = 1'b1;
            cyc();
            start1 = 1'b0;
            for (int c = 1; c <= 8; c++) begin
                if (shift1) sh++;
                if (done1 && dc == 0) dc = c;
                cyc();
            end
            chk("l1_shift_cycles", 32'(sh), 32'd1);
            chk("l1_done_cycle", 32'(dc), 32'd4);
            chk("l1_rd_data", 32'(rd_data1), (tcase == 0) ? 32'd0 : 32'd1);
            chk("l1_chain", 32'(ur1), (tcase == 0) ? 32'd1 : 32'd0);
            chk("l1_idle", 32'(busy1), 32'd0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wbr_access_ctrl.md
# wbr_access_ctrl

Serial access controller that drives a chain of wrapper boundary cells from the test-control side. It loads a parallel stimulus vector into the chain bit-serially and pulses the cell control strobes in the order capture, shift, transfer, update. It also returns the captured chain contents as a parallel vector. It sits between the wrapper instruction/test-access logic and the serially connected WBR cells, driving their `cti`/`shift`/`capture`/`transfer`/`update`/`mode`/`safe`/`io_face` pins and observing the last cell's `cto`.

## Interface
- `CHAIN_LEN`, 8: number of cells in the driven chain; legal range 1..1024.
- `CNT_W`, $clog2(CHAIN_LEN+1): shift counter width; derived, not overridden.

- `clk`  in  1  sole clock; all state changes on rising edge.
- `arst`  in  1  reset, synchronous, active-high (name kept for consistency with the cell ports; it is not asynchronous).
- `start`  in  1  request an access; sampled only in IDLE.
- `do_capture`  in  1  include capture phase; sampled with `start`.
- `do_transfer`  in  1  include transfer phase; sampled with `start`.
- `do_update`  in  1  include update phase; sampled with `start`.
- `cfg_mode`, `cfg_safe`, `cfg_io_face`  in  1 each  cell configuration; sampled with `start`.
- `wr_data`  in  CHAIN_LEN  stimulus; `wr_data[i]` lands in chain position i.
- `busy`  out  1  access in progress.
- `done`  out  1  one-cycle pulse at end of access.
- `rd_data`  out  CHAIN_LEN  captured chain contents; `rd_data[i]` = value shifted out of position i.
- `wsi`  out  1  serial data to first cell `cti`.
- `wso`  in  1  serial data from last cell `cto`.
- `shift`, `capture`, `transfer`, `update`  out  1 each  cell strobes.
- `mode`, `safe`, `io_face`  out  1 each  cell configuration, held for the whole access.

## Operation
- Chain position 0 is the cell adjacent to `wso`. Data shifts LSB first, so `wr_data[0]` goes first on `wsi`.
- States: IDLE, CAPTURE, SHIFT, TRANSFER, UPDATE, DONE.
- IDLE + `start`: latch op bits, cfg bits and `wr_data` into the TX shift register. Next state is CAPTURE if `do_capture`, else SHIFT.
- CAPTURE: `capture`=1 for exactly 1 cycle, then go to SHIFT.
- SHIFT: `shift`=1 for exactly CHAIN_LEN cycles.
  - `wsi` = TX[0]; TX shifts right each cycle.
  - `wso` is sampled at each shift edge into the RX register: the first sample goes to `rd_data[0]` and the last to `rd_data[CHAIN_LEN-1]`.
  - When the counter reaches CHAIN_LEN, go to TRANSFER if `do_transfer`, else UPDATE if `do_update`, else DONE.
- TRANSFER: `transfer`=1 for 1 cycle, then go to UPDATE if `do_update`, else DONE.
- UPDATE: `update`=1 for 1 cycle, then go to DONE.
- DONE: `done`=1 for 1 cycle, `rd_data` final, then return to IDLE.
- Strobes are one-hot; at most one of `shift`, `capture`, `transfer`, `update` is high in any cycle.
- `start` while not in IDLE is ignored.
- `rd_data` updates only during SHIFT and holds from DONE until the next SHIFT.
- With `do_capture`=0, `rd_data` returns the prior chain contents (pure shift).

## Timing
- Reset, synchronous with priority over all else: state IDLE; `busy`, `done`, `wsi`, all strobes, `mode`, `safe`, `io_face` are 0; `rd_data`, TX, RX and the counter are 0.
- Reset mid-access abandons it: outputs reach reset values at the edge that samples `arst`=1, and no `done` is issued.
- With `start` sampled at edge t, state changes at t. `busy`=1 from cycle t+1 through the DONE cycle inclusive.
- Access length, counted from the first cycle after t through DONE inclusive: `do_capture` + CHAIN_LEN + `do_transfer` + `do_update` + 1.
- Fastest start-to-start is back-to-back: `start` may be high in the cycle after DONE.
- `mode`, `safe`, `io_face` change only at the accepting edge and hold until the next accept or reset.
- CHAIN_LEN=1: SHIFT lasts 1 cycle and the counter must not wrap.

## Structure
- `wbr_pkg` holds:
  - the state enum typedef `wbr_acc_state_e`;
  - a packed struct `wbr_acc_op_t` with fields capture, transfer, update, mode, safe, io_face;
  - the strobe-encoding localparams.
- One sub-module, `wbr_shift_counter`: CNT_W-bit up counter with clear, enable and a terminal flag at CHAIN_LEN.
- The FSM, TX register and RX register stay in the top.

## Test plan
- CHAIN_LEN=8, behavioural 8-cell chain model, full op (capture/transfer/update=1), `wr_data`=8'hA5, chain preloaded to 8'h3C:
  - `rd_data`=8'h3C;
  - chain holds 8'hA5 after update;
  - `done` exactly 12 cycles after the start edge.
- Pure shift (all op bits 0), two back-to-back accesses with 8'h01 then 8'h80: second `rd_data`=8'h01; access length 9 cycles each; strobe one-hot checked every cycle.
- `start` pulsed during SHIFT of an access with 8'hFF: ignored; exactly one `done`; `rd_data` unaffected by the extra pulse.
- `arst` asserted at the 4th shift cycle:
  - every output reads its reset value in the following cycle;
  - no `done` pulse;
  - a new access after release completes normally.
- CHAIN_LEN=1, `wr_data`=1'b1, chain=1'b0, capture+update: SHIFT lasts 1 cycle; `rd_data`=0; chain=1; `done` at cycle 4.
- `cfg_mode`=1, `cfg_safe`=1, `cfg_io_face`=0 at accept: outputs held constant through DONE while the cfg inputs toggle every cycle.
